prio_arb_rr: RTL

Parametrised N-way request arbiter, the registered successor to the 4-to-2 priority encoder. It selects one requester and holds that grant until the owner releases it. Two modes are selectable at run time: fixed priority, where the highest index wins as in the encoder, and round-robin. Outputs are a one-hot grant, a binary grant index and a valid flag. It sits in front of shared resources such as a bus, a UART TX or a memory port.

---
 rtl/prio_arb_rr_if.sv | 14 +
 rtl/prio_arb_rr.sv | 84 ++++++++
 2 files changed

// File: rtl/prio_arb_rr_if.sv
// prio_arb_rr_if: request/grant bundle between requesters (master) and the arbiter (slave).
interface prio_arb_rr_if #(
  parameter int N = 4
) ();
  localparam int IDX_W = $clog2(N);
  logic [N-1:0]     req;
  logic             mode_rr;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;
  modport master (output req, mode_rr, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave (input req, mode_rr, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/prio_arb_rr.sv
// prio_arb_rr: N-way hold-until-release arbiter, fixed priority or round-robin; PRIO_ARB_TIMEOUT_EN adds a HOLD_MAX forced revoke.
module prio_arb_rr #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input logic          clk,
  input logic          reset,
  prio_arb_rr_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     cand, rot;
  logic [IDX_W-1:0] fix_idx, rr_idx, win_idx;
  logic             win_hit, own_req, force_rel, hold;
`ifdef PRIO_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  assign force_rel   = cnt_q == 8'(HOLD_MAX - 1);
  assign cnt_d       = hold ? cnt_q + 8'd1 : 8'd0;
  assign timeout_d   = own_req && force_rel;
  assign bus.timeout = timeout_q;
  always_ff @(posedge clk) begin
    cnt_q     <= reset ? 8'd0 : cnt_d;
    timeout_q <= reset ? 1'b0 : timeout_d;
  end
`else
  logic unused_hold_max;
  assign unused_hold_max = ^8'(HOLD_MAX);
  assign force_rel       = 1'b0;
  assign bus.timeout     = 1'b0;
`endif
  assign own_req = state_q == OWNED && |(bus.req & gnt_q);
  assign hold    = own_req && !force_rel;
  // The current owner never competes in its own re-arbitration.
  assign cand    = bus.req & ~gnt_q;
  assign rot     = N'({cand, cand} >> ptr_q);
  assign win_hit = |cand;
  assign win_idx = bus.mode_rr ? rr_idx : fix_idx;
  always_comb begin
    fix_idx = '0;
    rr_idx  = '0;
    for (int i = 0; i < N; i++)
      if (cand[i]) fix_idx = IDX_W'(i);
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) rr_idx = IDX_W'((int'(ptr_q) + i) % N);
  end
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    if (!hold) begin
      state_d     = win_hit ? OWNED : IDLE;
      gnt_d       = win_hit ? N'(1) << win_idx : '0;
      gnt_idx_d   = win_hit ? win_idx : '0;
      gnt_valid_d = win_hit;
      ptr_d       = !win_hit ? ptr_q : win_idx == IDX_W'(N - 1) ? '0 : win_idx + IDX_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
endmodule
